// File: rtl/n_alu_pkg.sv
// n_alu_pkg: shared constants for the n_alu block.
//   NUM_BITS_DEFAULT : default operand width
//   OP_*             : 2-bit op codes, formed as {s0,s1}; meaning depends on unit
//   UNIT_*           : unit select values carried on s3
package n_alu_pkg;

  localparam int NUM_BITS_DEFAULT = 4;

  // Arithmetic unit op codes (s3 = UNIT_ARITH)
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  // Logic unit op codes (s3 = UNIT_LOGIC)
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  localparam logic UNIT_ARITH = 1'b0;
  localparam logic UNIT_LOGIC = 1'b1;

endpackage

// File: rtl/n_alu_datapath.sv
// n_alu_datapath: purely combinational result generator.
//   a, b   : W-bit unsigned operands
//   s0, s1 : op code {s0,s1}
//   s3     : unit select (0 arithmetic, 1 logic)
//   result : W+1 bits; result[W] is carry out (arithmetic) or 0 (logic)
// All four arithmetic ops share one ripple-carry adder; only the second
// adder operand and the carry-in change per op.
module n_alu_datapath
  import n_alu_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEFAULT
) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                s0,
  input  logic                s1,
  input  logic                s3,
  output logic [NUM_BITS:0]   result
);

  logic [1:0]          op;
  logic [NUM_BITS-1:0] add_b;
  logic                add_cin;
  logic [NUM_BITS-1:0] add_sum;
  logic                add_cout;
  logic [NUM_BITS:0]   arith_res;
  logic [NUM_BITS:0]   logic_res;

  assign op = {s0, s1};

  // Adder operand-B / carry-in selection. SUB uses a + ~b + 1, DEC uses
  // a + all-ones, so carry out doubles as the "no borrow" indicator.
  always_comb begin
    add_b   = b;
    add_cin = 1'b0;
    unique case (op)
      OP_ADD: begin add_b = b;                  add_cin = 1'b0; end
      OP_SUB: begin add_b = ~b;                 add_cin = 1'b1; end
      OP_INC: begin add_b = '0;                 add_cin = 1'b1; end
      OP_DEC: begin add_b = {NUM_BITS{1'b1}};   add_cin = 1'b0; end
      default: begin add_b = b;                 add_cin = 1'b0; end
    endcase
  end

  // Ripple-carry adder; the carry is a blocking local so the chain is
  // evaluated bit by bit inside one combinational process.
  always_comb begin
    logic carry;
    carry   = add_cin;
    add_sum = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      add_sum[i] = a[i] ^ add_b[i] ^ carry;
      carry      = (a[i] & add_b[i]) | (carry & (a[i] ^ add_b[i]));
    end
    add_cout = carry;
  end

  assign arith_res = {add_cout, add_sum};

  // Logic unit; extra bit is always 0.
  always_comb begin
    logic_res = '0;
    unique case (op)
      OP_AND:  logic_res = {1'b0, a & b};
      OP_OR:   logic_res = {1'b0, a | b};
      OP_XOR:  logic_res = {1'b0, a ^ b};
      OP_SHR:  logic_res = {2'b00, a[NUM_BITS-1:1]};
      default: logic_res = '0;
    endcase
  end

  assign result = (s3 == UNIT_LOGIC) ? logic_res : arith_res;

endmodule

// File: rtl/n_alu.sv
// n_alu: registered W-bit ALU with an arithmetic and a logic unit.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears out immediately
//   a, b   : W-bit unsigned operands
//   s0, s1 : op code {s0,s1}
//   s3     : unit select (0 arithmetic, 1 logic)
//   out    : W+1-bit result registered one cycle after inputs are sampled
// There is no handshake: a new result is captured on every rising edge.
module n_alu
  import n_alu_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                s0,
  input  logic                s1,
  input  logic                s3,
  output logic [NUM_BITS:0]   out
);

  logic [NUM_BITS:0] result;

  n_alu_datapath #(.NUM_BITS(NUM_BITS)) u_datapath (
    .a      (a),
    .b      (b),
    .s0     (s0),
    .s1     (s1),
    .s3     (s3),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= result;
  end

endmodule

// File: tb/tb_n_alu.sv
// Self-checking bench for n_alu (W=4). The driver applies one vector per
// cycle on the falling edge and pushes the expected result; the monitor
// pops and compares #1 after each rising edge.
module tb_n_alu;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         s0;
  logic         s1;
  logic         s3;
  logic [W:0]   out;

  logic [W:0] exp_q[$];
  int total;
  int bad;

  n_alu #(.NUM_BITS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .s0    (s0),
    .s1    (s1),
    .s3    (s3),
    .out   (out)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent reference: plain integer arithmetic on W+1 bits
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic [1:0] op, input logic unit);
    logic [W:0]   r;
    logic [W-1:0] nb;
    logic [W-1:0] ones;
    ones = '1;
    nb   = ~rb;
    r    = '0;
    if (unit == 1'b0) begin
      case (op)
        2'b00: r = {1'b0, ra} + {1'b0, rb};
        2'b01: r = {1'b0, ra} + {1'b0, nb} + 1;
        2'b10: r = {1'b0, ra} + 1;
        default: r = {1'b0, ra} + {1'b0, ones};
      endcase
    end else begin
      case (op)
        2'b00: r = {1'b0, ra & rb};
        2'b01: r = {1'b0, ra | rb};
        2'b10: r = {1'b0, ra ^ rb};
        default: r = {1'b0, ra >> 1};
      endcase
    end
    return r;
  endfunction

  // Driver: apply a vector on the falling edge and record its expectation
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic [1:0] op, input logic unit, input logic [W:0] expv);
    @(negedge clk);
    a  = da;
    b  = db;
    s0 = op[1];
    s1 = op[0];
    s3 = unit;
    exp_q.push_back(expv);
  endtask

  task automatic check_now(input string name, input logic [W:0] expv);
    total++;
    if (out !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, out, expv);
    end
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [W:0] e;
      e = exp_q.pop_front();
      total++;
      if (out !== e) begin
        bad++;
        $display("FAIL result a=%b b=%b op=%b%b s3=%b: got %b expected %b",
                 a, b, s0, s1, s3, out, e);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a = '0; b = '0; s0 = 1'b0; s1 = 1'b0; s3 = 1'b0;
    // Hold inputs at a nonzero result while in reset to show out stays 0
    a = 4'b1111; b = 4'b1111;
    repeat (2) @(posedge clk);
    #1 check_now("reset_state", 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results
    drive(4'b1011, 4'b1111, 2'b00, 1'b0, 5'b1_1010);  // add with carry
    drive(4'b0101, 4'b0011, 2'b01, 1'b0, 5'b1_0010);  // sub, no borrow
    drive(4'b0011, 4'b0101, 2'b01, 1'b0, 5'b0_1110);  // sub, borrow
    drive(4'b0111, 4'b0111, 2'b01, 1'b0, 5'b1_0000);  // sub, equal
    drive(4'b1111, 4'b1010, 2'b10, 1'b0, 5'b1_0000);  // inc wrap, b ignored
    drive(4'b0110, 4'b0101, 2'b10, 1'b0, 5'b0_0111);  // inc
    drive(4'b0000, 4'b1001, 2'b11, 1'b0, 5'b0_1111);  // dec wrap
    drive(4'b1000, 4'b0000, 2'b11, 1'b0, 5'b1_0111);  // dec
    drive(4'b1100, 4'b1010, 2'b00, 1'b1, 5'b0_1000);  // and
    drive(4'b1100, 4'b1010, 2'b01, 1'b1, 5'b0_1110);  // or
    drive(4'b1100, 4'b1010, 2'b10, 1'b1, 5'b0_0110);  // xor
    drive(4'b1100, 4'b1010, 2'b11, 1'b1, 5'b0_0110);  // shr
    drive(4'b1111, 4'b0101, 2'b11, 1'b1, 5'b0_0111);  // shr, msb cleared
    drive(4'b1111, 4'b1111, 2'b00, 1'b1, 5'b0_1111);  // and, no extra bit

    // Asynchronous reset between edges
    drive(4'b1111, 4'b1111, 2'b00, 1'b0, 5'b1_1110);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", 5'b0_0000);
    exp_q.push_back(5'b1_1110);  // first edge after release recaptures
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Exhaustive sweep against the reference model
    for (int u = 0; u < 2; u++)
      for (int o = 0; o < 4; o++)
        for (int ia = 0; ia < (1 << W); ia++)
          for (int ib = 0; ib < (1 << W); ib++)
            drive(W'(ia), W'(ib), 2'(o), 1'(u),
                  ref_model(W'(ia), W'(ib), 2'(o), 1'(u)));

    // Drain
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n_alu.md
N_ALU -- requirements
Module: n_alu

Interface
REQ-001 Parameter: NUM_BITS, default 4, operand width W.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk, input, 1, rising-edge clock.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: a, input, W, operand A, unsigned.
REQ-006 Port: b, input, W, operand B, unsigned.
REQ-007 Port: s0, input, 1, operation select, high bit of the 2-bit op code.
REQ-008 Port: s1, input, 1, operation select, low bit of the 2-bit op code.
REQ-009 Port: s3, input, 1, unit select: 0 = arithmetic, 1 = logic.
REQ-010 Port: out, output, W+1, registered result; out[W] is the carry or extra bit.

Function
REQ-011 The result SHALL be computed combinationally from a, b, s0, s1 and s3, and registered into out on every rising clk edge.
- Latency: 1 cycle.
- No handshake; sampled every cycle.
REQ-012 Op code is {s0,s1}.
REQ-013 Arithmetic unit (s3=0), all sums mod 2^W in out[W-1:0]:
- 00: a+b; out[W] = carry out.
- 01: a+~b+1 (a-b); out[W] = carry out, 1 when a>=b, 0 on borrow.
- 10: a+1; out[W] = carry out, 1 only when a = all-ones.
- 11: a + all-ones (a-1); out[W] = carry out, 1 when a!=0, 0 when a=0 (result wraps to all-ones).
REQ-014 Logic unit (s3=1):
- 00: a AND b.
- 01: a OR b.
- 10: a XOR b.
- 11: a logical shift right by 1; out[W-1] = 0; b ignored.
- out[W] = 0 for every logic op.
REQ-015 Unused operands SHALL NOT affect the result: b is ignored for arithmetic 10/11 and logic 11.
REQ-016 All arithmetic SHALL be unsigned; no overflow flag is produced.
REQ-017 A change of any input between edges SHALL affect only the value captured at the next rising edge.

Reset
REQ-018 When rst_n is low, out SHALL be forced to 0 immediately, independent of clk.
REQ-019 On rst_n deassertion, the first rising clk edge SHALL capture the current operation result.
REQ-020 Reset asserted mid-stream SHALL discard the pending result; no stale value may reappear after reset.

Structure
REQ-021 A shared package n_alu_pkg SHALL hold:
- the NUM_BITS default;
- op-code constants: OP_ADD/OP_AND=00, OP_SUB/OP_OR=01, OP_INC/OP_XOR=10, OP_DEC/OP_SHR=11;
- unit-select constants: UNIT_ARITH=0, UNIT_LOGIC=1.
REQ-022 One combinational sub-module, n_alu_datapath, SHALL produce the W+1-bit result from (a, b, s0, s1, s3).
- It contains a ripple-carry adder shared by all four arithmetic ops, with operand-B/carry-in selection.
- It contains the logic ops and a 4:1 select per unit plus a 2:1 unit select.
- n_alu instantiates it and holds only the output register.
REQ-023 The design SHALL be fully parameterized by NUM_BITS; there SHALL be no 4-bit hard coding.

Verification (W=4)
REQ-024 Add with carry: a=1011, b=1111, s0=0, s1=0, s3=0 -> out=1_1010 one cycle after the edge.
REQ-025 Subtract:
- a=0101, b=0011, op 01, s3=0 -> out=1_0010.
- a=0011, b=0101 -> out=0_1110.
REQ-026 Increment/decrement boundaries:
- INC a=1111 -> 1_0000.
- DEC a=0000 -> 0_1111.
- DEC a=1000 -> 1_0111.
REQ-027 Logic, a=1100, b=1010, s3=1:
- AND -> 0_1000.
- OR -> 0_1110.
- XOR -> 0_0110.
- SHR -> 0_0110.
REQ-028 Reset: drive ADD 1111+1111 -> out=1_1110.
- Assert rst_n=0 between edges -> out=0_0000 immediately, with no clk edge.
- Release -> next edge shows 1_1110 again.
REQ-029 Exhaustive sweep: all a, b, {s0,s1}, s3 compared against a reference model, with out checked one cycle later.
